// File: rtl/dmem_access_pkg.sv
// Shared types and defaults for the data-memory access stage.
//   state_e       : access FSM encoding (Idle, Req, Done)
//   DmemAddrW     : default address width
//   DmemDataW     : default data width
package dmem_access_pkg;

  localparam int unsigned DmemAddrW = 32;
  localparam int unsigned DmemDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_access.sv
// Data-memory access stage between EX_MEM and MEM_WB.
// Turns MemRead/MemWrite into a req/ack transaction on the data-memory port and stalls the
// pipeline until the memory responds. Non-memory instructions pass through in one cycle.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   ALUResult_i, WriteData_i     address/ALU result and store data from EX_MEM
//   MemRead_i, MemWrite_i        access request (write wins if both set)
//   RegWrite_i, MemToReg_i       writeback control from EX_MEM
//   ALUResult_o, RDData_o        ALU result pass-through and captured load data to MEM_WB
//   RegWrite_o, MemToReg_o       writeback control to MEM_WB
//   stall_o                      freezes PC and all upstream pipeline registers
//   mem_req_o, mem_we_o          registered request / write-enable
//   mem_addr_o, mem_wdata_o      registered address / store data
//   mem_ack_i, mem_rdata_i       one-cycle completion pulse and load data
//   misalign_o                   misaligned access flag (DONE cycle only)
//
// Build option: DMEM_MISALIGN_CHECK_EN makes accesses with a non word-aligned address skip the
// memory, go straight to DONE, raise misalign_o and suppress RegWrite_o in that cycle.
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = DmemAddrW,
  parameter int unsigned DATA_W = DmemDataW
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  output logic [ADDR_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] RDData_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              misalign_o
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              access;
  logic              misaligned;

  assign access = MemRead_i | MemWrite_i;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = (ALUResult_i[1:0] != 2'b00);

  // Remembers that the access which led into DONE was rejected as misaligned.
  logic mis_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mis_q <= 1'b0;
    end else if (state_q == StIdle) begin
      mis_q <= access & misaligned;
    end
  end

  assign misalign_o = (state_q == StDone) & mis_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          stall_o = 1'b1;
          if (misaligned) begin
            state_d = StDone;
          end else begin
            req_d   = 1'b1;
            we_d    = MemWrite_i;
            addr_d  = ALUResult_i;
            wdata_d = WriteData_i;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end
      end
      // One unstalled cycle so MEM_WB samples RDData_o and the pipeline advances.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RDData_o    = rdata_q;
  assign ALUResult_o = ALUResult_i;
  assign MemToReg_o  = MemToReg_i;
  assign RegWrite_o  = RegWrite_i & ~misalign_o;

endmodule

// File: tb/tb_dmem_access.sv
// Directed self-checking bench for dmem_access.
module tb_dmem_access;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_res;
  logic [31:0] wr_data;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] alu_res_out;
  logic [31:0] rd_data_out;
  logic        reg_write_out;
  logic        mem_to_reg_out;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  dmem_access u_dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .ALUResult_i (alu_res),
    .WriteData_i (wr_data),
    .MemRead_i   (mem_read),
    .MemWrite_i  (mem_write),
    .RegWrite_i  (reg_write),
    .MemToReg_i  (mem_to_reg),
    .ALUResult_o (alu_res_out),
    .RDData_o    (rd_data_out),
    .RegWrite_o  (reg_write_out),
    .MemToReg_o  (mem_to_reg_out),
    .stall_o     (stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .misalign_o  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_instr(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic rw, input logic m2r);
    mem_read   = rd;
    mem_write  = wr;
    alu_res    = addr;
    wr_data    = wd;
    reg_write  = rw;
    mem_to_reg = m2r;
  endtask

  // Runs one instruction already on the inputs until the stage stops stalling. Acks on the
  // ack_at-th request cycle. Called just after a rising edge; returns just after the edge that
  // ends the unstalled cycle.
  task automatic run_access(input int ack_at, input logic [31:0] rd, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                            output int stall_cnt, output int req_cnt, output int lat,
                            output logic [31:0] done_rd, output logic done_mis,
                            output logic done_rw);
    bit done;
    done      = 1'b0;
    stall_cnt = 0;
    req_cnt   = 0;
    lat       = 0;
    done_rd   = '0;
    done_mis  = 1'b0;
    done_rw   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (mem_req) begin
        req_cnt++;
        check("req_we", 32'(mem_we), 32'(exp_we));
        check("req_addr", mem_addr, exp_addr);
        check("req_wdata", mem_wdata, exp_wd);
        if (req_cnt == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
      @(negedge clk);
      lat++;
      if (stall) begin
        stall_cnt++;
      end else begin
        done     = 1'b1;
        done_rd  = rd_data_out;
        done_mis = misalign;
        done_rw  = reg_write_out;
      end
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sc, rc, lat;
    logic [31:0] drd;
    logic        dmis, drw;

    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rddata", rd_data_out, 32'h0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add: pure pass-through, one cycle, never stalls
    set_instr(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    #1;
    check("add_alu_out", alu_res_out, 32'h10);
    check("add_regwrite", 32'(reg_write_out), 32'd1);
    check("add_memtoreg", 32'(mem_to_reg_out), 32'd0);
    run_access(1, 32'h0, 1'b0, 32'h0, 32'h0, sc, rc, lat, drd, dmis, drw);
    check("add_stall_cycles", 32'(sc), 32'd0);
    check("add_req_cycles", 32'(rc), 32'd0);
    check("add_latency", 32'(lat), 32'd1);

    // lw 0x40, ack on 3rd request cycle
    set_instr(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    run_access(3, 32'hDEADBEEF, 1'b0, 32'h40, 32'h0, sc, rc, lat, drd, dmis, drw);
    check("lw_stall_cycles", 32'(sc), 32'd4);
    check("lw_req_cycles", 32'(rc), 32'd3);
    check("lw_latency", 32'(lat), 32'd5);
    check("lw_rddata_done", drd, 32'hDEADBEEF);
    check("lw_misalign", 32'(dmis), 32'd0);
    check("lw_regwrite_done", 32'(drw), 32'd1);
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("lw_req_after", 32'(mem_req), 32'd0);

    // sw 0x12345678 to 0x80, ack in 1st request cycle; load data must survive
    set_instr(1'b0, 1'b1, 32'h80, 32'h12345678, 1'b0, 1'b0);
    run_access(1, 32'hA5A5A5A5, 1'b1, 32'h80, 32'h12345678, sc, rc, lat, drd, dmis, drw);
    check("sw_stall_cycles", 32'(sc), 32'd2);
    check("sw_req_cycles", 32'(rc), 32'd1);
    check("sw_latency", 32'(lat), 32'd3);
    check("sw_rddata_kept", drd, 32'hDEADBEEF);
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("sw_we_after", 32'(mem_we), 32'd0);

    // stray ack while idle is ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    @(negedge clk);
    check("stray_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("stray_req", 32'(mem_req), 32'd0);
    check("stray_rddata", rd_data_out, 32'hDEADBEEF);

    // lw with ack on 2nd request cycle
    set_instr(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1);
    run_access(2, 32'hCAFEF00D, 1'b0, 32'h44, 32'h0, sc, rc, lat, drd, dmis, drw);
    check("lw2_latency", 32'(lat), 32'd4);
    check("lw2_req_cycles", 32'(rc), 32'd2);
    check("lw2_rddata_done", drd, 32'hCAFEF00D);
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // reset pulsed while in REQ
    set_instr(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("rstmid_req_before", 32'(mem_req), 32'd1);
    check("rstmid_stall_before", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rstmid_req", 32'(mem_req), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_we", 32'(mem_we), 32'd0);
    check("rstmid_rddata", rd_data_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h99999999;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("rstmid_late_ack_req", 32'(mem_req), 32'd0);
    check("rstmid_late_ack_rddata", rd_data_out, 32'h0);
    set_instr(1'b0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    run_access(1, 32'h0, 1'b0, 32'h0, 32'h0, sc, rc, lat, drd, dmis, drw);
    check("rstmid_idle_latency", 32'(lat), 32'd1);

`ifdef DMEM_MISALIGN_CHECK_EN
    // misaligned lw: no request, straight to DONE with misalign and RegWrite suppressed
    set_instr(1'b1, 1'b0, 32'h42, 32'h0, 1'b1, 1'b1);
    run_access(1, 32'h0, 1'b0, 32'h0, 32'h0, sc, rc, lat, drd, dmis, drw);
    check("mis_req_cycles", 32'(rc), 32'd0);
    check("mis_latency", 32'(lat), 32'd2);
    check("mis_flag_done", 32'(dmis), 32'd1);
    check("mis_regwrite_done", 32'(drw), 32'd0);
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("mis_flag_after", 32'(misalign), 32'd0);
    check("mis_regwrite_after", 32'(reg_write_out), 32'd1);
`else
    // without the check a misaligned lw goes to memory unmodified
    set_instr(1'b1, 1'b0, 32'h42, 32'h0, 1'b1, 1'b1);
    run_access(1, 32'h0BADF00D, 1'b0, 32'h42, 32'h0, sc, rc, lat, drd, dmis, drw);
    check("nomis_req_cycles", 32'(rc), 32'd1);
    check("nomis_latency", 32'(lat), 32'd3);
    check("nomis_flag", 32'(dmis), 32'd0);
    check("nomis_rddata", drd, 32'h0BADF00D);
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
